// File: rtl/wb_pkg.sv
// Shared write-back definitions: data/register widths and the write-back request record.
package wb_pkg;
   localparam int XLEN   = 32;
   localparam int NREGS  = 32;
   localparam int REG_AW = 5;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] addr;
      logic [XLEN-1:0]   data;
   } wb_req_t;
endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue, cleared after the write edge.
module wb_scoreboard
   import wb_pkg::REG_AW;
#(
   parameter int NREGS = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              set_en,
   input  logic [REG_AW-1:0] set_addr,
   input  logic              clr_en,
   input  logic [REG_AW-1:0] clr_addr,
   input  logic [REG_AW-1:0] chk_ra1,
   input  logic [REG_AW-1:0] chk_ra2,
   output logic              busy
);
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_next;

   always_comb begin
      // NOTE: starting from the held value gives busy_next a value on every path, so no latch is inferred.
      busy_next = busy_q;
      if (clr_en) busy_next[clr_addr] = 1'b0;
      // Applied after the clear so a coincident issue keeps the register pending.
      if (set_en) busy_next[set_addr] = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      // NOTE: the busy bits are individual flops rather than a RAM, so they are cleared by reset.
      if (reset) busy_q <= '0;
      else       busy_q <= busy_next;
   end

   // Register 0 is never pending, so it can never stall issue.
   assign busy = (chk_ra1 != '0 && busy_q[chk_ra1]) ||
                 (chk_ra2 != '0 && busy_q[chk_ra2]);
endmodule

// File: rtl/wb_arbiter.sv
// Two-requester write-back arbiter with registered register-file write port and pending scoreboard.
// Build option WB_ARB_RR_EN selects round-robin; default is fixed priority favouring the load unit.
module wb_arbiter
   import wb_pkg::REG_AW, wb_pkg::wb_req_t;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic [REG_AW-1:0] req0_addr,
   input  logic [XLEN-1:0]   req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [REG_AW-1:0] req1_addr,
   input  logic [XLEN-1:0]   req1_data,
   output logic              req1_ready,
   input  logic              iss_valid,
   input  logic [REG_AW-1:0] iss_rd,
   input  logic [REG_AW-1:0] chk_ra1,
   input  logic [REG_AW-1:0] chk_ra2,
   output logic              chk_busy,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_wa,
   output logic [XLEN-1:0]   rf_wd
);
   wb_req_t req0, req1, win;
   logic    grant0, grant1, wr;

   assign req0 = '{valid: req0_valid, addr: req0_addr, data: req0_data};
   assign req1 = '{valid: req1_valid, addr: req1_addr, data: req1_data};

`ifdef WB_ARB_RR_EN
   logic prio1;  // requester 1 wins the next contested cycle

   assign grant0 = !reset && req0.valid && (!req1.valid || !prio1);
   assign grant1 = !reset && req1.valid && (!req0.valid || prio1);

   always_ff @(posedge clk) begin
      if (reset)       prio1 <= 1'b0;
      else if (grant0) prio1 <= 1'b1;
      else if (grant1) prio1 <= 1'b0;
   end
`else
   assign grant1 = !reset && req1.valid;
   assign grant0 = !reset && req0.valid && !req1.valid;
`endif

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign win        = grant1 ? req1 : req0;
   // Writes to x0 complete the handshake but never reach the register file.
   assign wr         = (grant0 || grant1) && win.addr != '0;

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      if (reset) begin
         rf_we <= 1'b0;
         rf_wa <= '0;
         rf_wd <= '0;
      end else begin
         rf_we <= wr;
         if (wr) begin
            rf_wa <= win.addr;
            rf_wd <= win.data;
         end
      end
   end

   wb_scoreboard #(.NREGS(NREGS)) u_scoreboard (
      .clk      (clk),
      .reset    (reset),
      .set_en   (iss_valid),
      .set_addr (iss_rd),
      .clr_en   (rf_we),
      .clr_addr (rf_wa),
      .chk_ra1  (chk_ra1),
      .chk_ra2  (chk_ra2),
      .busy     (chk_busy)
   );
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_wb_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid, iss_valid;
   logic [4:0]  req0_addr, req1_addr, iss_rd, chk_ra1, chk_ra2;
   logic [31:0] req0_data, req1_data;
   logic        req0_ready, req1_ready, chk_busy, rf_we;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd;

   wb_arbiter #(.XLEN(32), .NREGS(32)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .chk_ra1(chk_ra1), .chk_ra2(chk_ra2),
      .chk_busy(chk_busy), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Behavioural model: set of pending registers, last granted requester, expected write port.
   bit          mbusy[32];
   int          m_last = 1;
   bit          m_we;
   logic [4:0]  m_wa;
   logic [31:0] m_wd;

   function automatic int m_grant();
      if (reset) return -1;
      if (req0_valid && req1_valid) begin
`ifdef WB_ARB_RR_EN
         return (m_last == 0) ? 1 : 0;
`else
         return 1;
`endif
      end
      if (req0_valid) return 0;
      if (req1_valid) return 1;
      return -1;
   endfunction

   function automatic logic [1:0] m_ready();  // {ready1, ready0}
      int g;
      g = m_grant();
      return {g == 1, g == 0};
   endfunction

   function automatic bit m_chk();
      return (chk_ra1 != 0 && mbusy[chk_ra1]) || (chk_ra2 != 0 && mbusy[chk_ra2]);
   endfunction

   // Advance one clock and update the model from the inputs presented in the cycle just ended.
   task automatic tick();
      int          g;
      bit          rst_s, iv;
      logic [4:0]  rd, a;
      logic [31:0] d;
      rst_s = reset;
      g     = m_grant();
      iv    = iss_valid;
      rd    = iss_rd;
      a     = (g == 1) ? req1_addr : req0_addr;
      d     = (g == 1) ? req1_data : req0_data;
      @(posedge clk);
      if (rst_s) begin
         foreach (mbusy[i]) mbusy[i] = 1'b0;
         m_we = 1'b0; m_wa = '0; m_wd = '0; m_last = 1;
      end else begin
         if (m_we) mbusy[m_wa] = 1'b0;
         if (iv && rd != 0) mbusy[rd] = 1'b1;
         if (g >= 0) m_last = g;
         m_we = (g >= 0) && (a != 0);
         if (m_we) begin
            m_wa = a;
            m_wd = d;
         end
      end
      #1;
   endtask

   task automatic idle();
      reset = 1'b0;
      req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
      req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
      iss_valid = 1'b0; iss_rd = '0; chk_ra1 = '0; chk_ra2 = '0;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      req0_valid = 1'b1; req0_addr = 5'd2; req1_valid = 1'b1; req1_addr = 5'd3;
      #1;
      vectors++;
      if ({req1_ready, req0_ready} !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_ready got=%b exp=00", {req1_ready, req0_ready});
      end
      tick(); tick();
      chk_ra1 = 5'd7; chk_ra2 = 5'd31;
      #1;
      vectors++;
      if ({rf_we, rf_wa, rf_wd, chk_busy} !== 39'd0) begin
         miscompares++;
         $display("FAIL reset_state got we=%b wa=%0d wd=%h busy=%b exp all zero", rf_we, rf_wa, rf_wd, chk_busy);
      end
      idle();
   endtask

   task automatic test_lone();
      idle();
      req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
      #1;
      vectors++;
      if ({req1_ready, req0_ready} !== 2'b01 || {req1_ready, req0_ready} !== m_ready()) begin
         miscompares++;
         $display("FAIL lone_ready got=%b exp=01", {req1_ready, req0_ready});
      end
      tick();
      req0_valid = 1'b0;
      vectors++;
      if (rf_we !== 1'b1 || rf_wa !== 5'd5 || rf_wd !== 32'hDEADBEEF || rf_wd !== m_wd) begin
         miscompares++;
         $display("FAIL lone_write got we=%b wa=%0d wd=%h exp we=1 wa=5 wd=deadbeef", rf_we, rf_wa, rf_wd);
      end
      tick();
      vectors++;
      if (rf_we !== 1'b0 || rf_wa !== 5'd5 || rf_wd !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL lone_after got we=%b wa=%0d wd=%h exp we=0 wa=5 wd=deadbeef (held)", rf_we, rf_wa, rf_wd);
      end
   endtask

   task automatic test_contention();
`ifdef WB_ARB_RR_EN
      int order[4] = '{0, 1, 0, 1};
`else
      int order[4] = '{1, 1, 1, 1};
`endif
      int g;
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      req0_valid = 1'b1; req0_addr = 5'd3; req0_data = $urandom;
      req1_valid = 1'b1; req1_addr = 5'd4; req1_data = $urandom;
      for (int i = 0; i < 4; i++) begin
         #1;
         g = m_grant();
         vectors++;
         if ({req1_ready, req0_ready} !== m_ready() || g != order[i]) begin
            miscompares++;
            $display("FAIL contend_grant[%0d] got=%b exp_requester=%0d", i, {req1_ready, req0_ready}, order[i]);
         end
         tick();
         vectors++;
         if (rf_we !== 1'b1 || rf_wa !== ((order[i] == 1) ? 5'd4 : 5'd3) || rf_wd !== m_wd) begin
            miscompares++;
            $display("FAIL contend_write[%0d] got we=%b wa=%0d wd=%h exp wa=%0d wd=%h", i, rf_we, rf_wa, rf_wd, m_wa, m_wd);
         end
         if (g == 0) req0_data = $urandom;
         if (g == 1) req1_data = $urandom;
      end
      req1_valid = 1'b0;
      #1;
      vectors++;
      if ({req1_ready, req0_ready} !== 2'b01) begin
         miscompares++;
         $display("FAIL contend_release got=%b exp=01", {req1_ready, req0_ready});
      end
      tick();
      idle();
      tick();
   endtask

   task automatic test_scoreboard();
      idle();
      iss_valid = 1'b1; iss_rd = 5'd7;
      tick();
      iss_valid = 1'b0; chk_ra1 = 5'd7;
      for (int i = 0; i < 3; i++) begin
         #1;
         vectors++;
         if (chk_busy !== 1'b1 || chk_busy !== m_chk()) begin
            miscompares++;
            $display("FAIL sb_pending[%0d] got=%b exp=1", i, chk_busy);
         end
         if (i == 2) begin
            req0_valid = 1'b1; req0_addr = 5'd7; req0_data = $urandom;
         end
         tick();
      end
      req0_valid = 1'b0;
      #1;
      vectors++;
      if (rf_we !== 1'b1 || rf_wa !== 5'd7 || chk_busy !== 1'b1) begin
         miscompares++;
         $display("FAIL sb_write_cycle got we=%b wa=%0d busy=%b exp we=1 wa=7 busy=1", rf_we, rf_wa, chk_busy);
      end
      tick();
      vectors++;
      if (chk_busy !== 1'b0 || chk_busy !== m_chk()) begin
         miscompares++;
         $display("FAIL sb_cleared got=%b exp=0", chk_busy);
      end
   endtask

   task automatic test_same_edge();
      idle();
      iss_valid = 1'b1; iss_rd = 5'd9;
      tick();
      iss_valid = 1'b0;
      req1_valid = 1'b1; req1_addr = 5'd9; req1_data = $urandom;
      tick();
      req1_valid = 1'b0;
      iss_valid = 1'b1; iss_rd = 5'd9;
      vectors++;
      if (rf_we !== 1'b1 || rf_wa !== 5'd9) begin
         miscompares++;
         $display("FAIL same_edge_write got we=%b wa=%0d exp we=1 wa=9", rf_we, rf_wa);
      end
      tick();
      iss_valid = 1'b0; chk_ra2 = 5'd9;
      for (int i = 0; i < 2; i++) begin
         #1;
         vectors++;
         if (chk_busy !== 1'b1 || chk_busy !== m_chk()) begin
            miscompares++;
            $display("FAIL same_edge_busy[%0d] got=%b exp=1", i, chk_busy);
         end
         tick();
      end
   endtask

   task automatic test_x0_reset();
      logic [4:0] regs[3] = '{5'd3, 5'd12, 5'd31};
      idle();
      req0_valid = 1'b1; req0_addr = 5'd0; req0_data = $urandom;
      #1;
      vectors++;
      if (req0_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL x0_ready got=%b exp=1", req0_ready);
      end
      tick();
      req0_valid = 1'b0;
      iss_valid = 1'b1; iss_rd = 5'd0;
      vectors++;
      if (rf_we !== 1'b0) begin
         miscompares++;
         $display("FAIL x0_we got=%b exp=0", rf_we);
      end
      tick();
      iss_valid = 1'b0;
      #1;
      vectors++;
      if (chk_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL x0_busy got=%b exp=0", chk_busy);
      end
      foreach (regs[i]) begin
         iss_valid = 1'b1; iss_rd = regs[i];
         tick();
      end
      iss_valid = 1'b0; chk_ra1 = 5'd31;
      #1;
      vectors++;
      if (chk_busy !== 1'b1) begin
         miscompares++;
         $display("FAIL pre_reset_busy got=%b exp=1", chk_busy);
      end
      reset = 1'b1;
      req0_valid = 1'b1; req0_addr = 5'd6; req0_data = $urandom;
      #1;
      vectors++;
      if (req0_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_pending_ready got=%b exp=0", req0_ready);
      end
      tick();
      reset = 1'b0;
      vectors++;
      if (rf_we !== 1'b0) begin
         miscompares++;
         $display("FAIL post_reset_we got=%b exp=0", rf_we);
      end
      foreach (regs[i]) begin
         chk_ra1 = regs[i]; chk_ra2 = regs[(i + 1) % 3];
         #1;
         vectors++;
         if (chk_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_busy[%0d] got=%b exp=0", regs[i], chk_busy);
         end
      end
      vectors++;
      if (req0_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL represent_ready got=%b exp=1", req0_ready);
      end
      tick();
      req0_valid = 1'b0;
      vectors++;
      if (rf_we !== 1'b1 || rf_wa !== 5'd6 || rf_wd !== m_wd) begin
         miscompares++;
         $display("FAIL represent_write got we=%b wa=%0d wd=%h exp we=1 wa=6 wd=%h", rf_we, rf_wa, rf_wd, m_wd);
      end
      tick();
   endtask

   task automatic test_random();
      bit p0 = 0, p1 = 0;
      int g;
      idle();
      for (int n = 0; n < 400; n++) begin
         reset = ($urandom_range(0, 39) == 0);
         if (!p0 && $urandom_range(0, 2) != 0) begin
            p0 = 1; req0_addr = 5'($urandom); req0_data = $urandom;
         end
         if (!p1 && $urandom_range(0, 2) != 0) begin
            p1 = 1; req1_addr = 5'($urandom); req1_data = $urandom;
         end
         req0_valid = p0; req1_valid = p1;
         iss_valid = $urandom_range(0, 1); iss_rd = 5'($urandom);
         chk_ra1 = 5'($urandom); chk_ra2 = 5'($urandom);
         #1;
         g = m_grant();
         vectors++;
         if ({req1_ready, req0_ready} !== m_ready() || chk_busy !== m_chk()) begin
            miscompares++;
            $display("FAIL rand_comb[%0d] got rdy=%b busy=%b exp rdy=%b busy=%b", n,
                     {req1_ready, req0_ready}, chk_busy, m_ready(), m_chk());
         end
         tick();
         if (g == 0) p0 = 0;
         if (g == 1) p1 = 0;
         vectors++;
         if (rf_we !== m_we || (m_we && (rf_wa !== m_wa || rf_wd !== m_wd))) begin
            miscompares++;
            $display("FAIL rand_write[%0d] got we=%b wa=%0d wd=%h exp we=%b wa=%0d wd=%h", n,
                     rf_we, rf_wa, rf_wd, m_we, m_wa, m_wd);
         end
      end
      idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_lone();
      test_contention();
      test_scoreboard();
      test_same_edge();
      test_x0_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter XLEN, default 32, data width of the write-back path.
REQ-002 Parameter NREGS, default 32, register count; address width is log2(NREGS) = 5.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0_valid / req0_addr / req0_data  input  1/5/XLEN  ALU write-back request.
REQ-006 req0_ready  output  1  ALU request accepted this cycle.
REQ-007 req1_valid / req1_addr / req1_data  input  1/5/XLEN  load-unit write-back request.
REQ-008 req1_ready  output  1  load request accepted this cycle.
REQ-009 iss_valid / iss_rd  input  1/5  issue marks destination register pending.
REQ-010 chk_ra1 / chk_ra2  input  5/5  source registers of the instruction being issued.
REQ-011 chk_busy  output  1  a checked source has a write pending; issue must stall.
REQ-012 rf_we / rf_wa / rf_wd  output  1/5/XLEN  drive the register file's single write port.

Function
REQ-013 Handshake: transfer occurs when valid and ready are both high on a rising edge; the requester holds valid, addr and data stable until ready.
REQ-014 readyN is combinational from the valid inputs and arbiter state; at most one ready is high per cycle.
REQ-015 A lone valid requester receives ready in the same cycle, with no bubble.
REQ-016 If both are valid, the grant follows the priority rule in REQ-028/029; the loser stays pending with ready low.
REQ-017 Latency: a transfer accepted at edge N drives rf_we=1, rf_wa=addr, rf_wd=data for exactly the cycle following edge N.
REQ-018 rf_we is low in every cycle with no accepted transfer; rf_wa/rf_wd hold their last value.
REQ-019 A transfer with addr=0 is accepted (ready high) but produces rf_we=0.
REQ-020 Scoreboard: 32 busy bits; iss_valid with iss_rd!=0 sets busy[iss_rd] at the edge.
REQ-021 busy[rf_wa] clears at the edge that ends a cycle with rf_we=1.
REQ-022 If set and clear of the same register coincide, set wins and busy stays 1.
REQ-023 busy[0] is permanently 0.
REQ-024 chk_busy = (chk_ra1!=0 and busy[chk_ra1]) or (chk_ra2!=0 and busy[chk_ra2]), combinational.
REQ-025 chk_busy does not forward rf_wd: a register clears only after its write edge.

Reset
REQ-026 While reset is high at an edge: all busy bits clear, rf_we=0, rf_wa=0, rf_wd=0, priority pointer set to requester 0.
REQ-027 Transfers presented during a reset cycle are not accepted (ready forced low), including one pending mid-handshake; the requester re-presents it after reset.

Configuration
REQ-028 With WB_ARB_RR_EN defined: round-robin. After granting requester k, the other requester wins the next contested cycle; uncontested grants also update the pointer.
REQ-029 Without WB_ARB_RR_EN: fixed priority. Requester 1 (load) always wins a contest; no pointer state exists.

Structure
REQ-030 Shared package wb_pkg holds XLEN, NREGS, REG_AW=5 and the write-back request struct (valid, addr, data).
REQ-031 The scoreboard is sub-module wb_scoreboard (set port, clear port, two check ports, busy output); the arbiter and output register stay in wb_arbiter.

Verification
REQ-032 Test 1, lone request: req0 valid, addr=5, data=0xDEADBEEF.
  - Required: req0_ready same cycle.
  - Required: next cycle rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF; the cycle after, rf_we=0.
REQ-033 Test 2, contention: both valid for 4 cycles, addr 3 and 4.
  - RR build, required grant order: 0,1,0,1 (or 1,0,1,0 per pointer).
  - Fixed build, required grant order: 1 for the first transfer, then 0 once req1 drops.
REQ-034 Test 3, scoreboard: issue rd=7, then chk_ra1=7.
  - Required: chk_busy=1 until rf_we with rf_wa=7 has occurred, then 0 in the next cycle.
REQ-035 Test 4, same-edge set and clear: issue rd=9 on the same edge that completes the write of 9.
  - Required: busy[9] remains 1, so chk_busy=1 for chk_ra2=9.
REQ-036 Test 5, x0 and reset:
  - Write to addr 0: required ready=1 and rf_we=0.
  - Issue rd=0: required chk_busy=0 for chk_ra1=0.
  - Assert reset with busy bits set: required all chk_busy=0 and rf_we=0 afterward.
